// File: rtl/cache_req_arbiter_if.sv
// Requester-side and cache-side signal bundle for the cache request arbiter.
// The slave modport is the arbiter's view; the master modport is the view of the core and cache around it.
interface cache_req_arbiter_if #(
    parameter int ADDRESS_WIDTH   = 32,
    parameter int CACHE_LINE_SIZE = 32,
    parameter int NUM_REQ         = 2
);
    logic [NUM_REQ-1:0]                 req_valid;
    logic [NUM_REQ-1:0]                 req_ready;
    logic [NUM_REQ*ADDRESS_WIDTH-1:0]   req_address;
    logic [NUM_REQ*CACHE_LINE_SIZE-1:0] req_data;
    logic [NUM_REQ-1:0]                 req_wen;
    logic [NUM_REQ-1:0]                 resp_valid;
    logic [NUM_REQ-1:0]                 resp_error;
    logic [CACHE_LINE_SIZE-1:0]         resp_data;
    logic                               cache_req_valid;
    logic [ADDRESS_WIDTH-1:0]           cache_address;
    logic [CACHE_LINE_SIZE-1:0]         cache_data_in;
    logic                               cache_wen;
    logic [CACHE_LINE_SIZE-1:0]         cache_data_out;
    logic                               cache_hit;

    modport slave (
        input  req_valid, req_address, req_data, req_wen, cache_data_out, cache_hit,
        output req_ready, resp_valid, resp_error, resp_data,
               cache_req_valid, cache_address, cache_data_in, cache_wen
    );

    modport master (
        output req_valid, req_address, req_data, req_wen, cache_data_out, cache_hit,
        input  req_ready, resp_valid, resp_error, resp_data,
               cache_req_valid, cache_address, cache_data_in, cache_wen
    );
endinterface

// File: rtl/cache_req_arbiter.sv
// Round-robin arbiter that shares one cache CPU port between NUM_REQ requesters.
// It holds each granted request on the cache until it hits, and a watchdog turns a stuck request into an error response.
module cache_req_arbiter #(
    parameter int ADDRESS_WIDTH   = 32,
    parameter int CACHE_LINE_SIZE = 32,
    parameter int NUM_REQ         = 2,
    parameter int TIMEOUT_CYCLES  = 1023
) (
    input  logic                clk,
    input  logic                rst,
    cache_req_arbiter_if.slave  bus
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [NUM_REQ-1:0] REQ_ZERO  = {NUM_REQ{1'b0}};
    localparam logic [NUM_REQ-1:0] REQ_ONE   = {{(NUM_REQ-1){1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0]   PTR_LAST  = PTR_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                     r_state;
    state_t                     w_next_state;
    logic [PTR_W-1:0]           r_rr_ptr;
    logic [PTR_W-1:0]           r_grant;
    logic [CNT_W-1:0]           r_cnt;
    logic                       r_err;
    logic [ADDRESS_WIDTH-1:0]   r_cache_address;
    logic [CACHE_LINE_SIZE-1:0] r_cache_data_in;
    logic                       r_cache_wen;
    logic [CACHE_LINE_SIZE-1:0] r_resp_data;

    logic                       w_win_found;
    logic [PTR_W-1:0]           w_win_idx;
    logic                       w_timeout;
    logic [NUM_REQ-1:0]         w_req_ready;
    logic [NUM_REQ-1:0]         w_resp_valid;
    logic [NUM_REQ-1:0]         w_resp_error;
    logic                       w_cache_req_valid;
    logic                       w_cache_wen;

    // Round-robin search: walk offsets from farthest to nearest so the requester closest to rr_ptr wins.
    always_comb begin
        int idx;
        w_win_found = 1'b0;
        w_win_idx   = {PTR_W{1'b0}};
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx         = (int'(r_rr_ptr) + k) % NUM_REQ;
            w_win_found = w_win_found | bus.req_valid[PTR_W'(idx)];
            w_win_idx   = bus.req_valid[PTR_W'(idx)] ? PTR_W'(idx) : w_win_idx;
        end
    end

    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; a hit takes priority over the watchdog.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  w_next_state = w_win_found ? S_WAIT : S_IDLE;
            S_WAIT:  w_next_state = (bus.cache_hit || w_timeout) ? S_RESP : S_WAIT;
            S_RESP:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Request latch, watchdog counter, response capture and round-robin pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_ptr        <= {PTR_W{1'b0}};
            r_grant         <= {PTR_W{1'b0}};
            r_cnt           <= {CNT_W{1'b0}};
            r_err           <= 1'b0;
            r_cache_address <= {ADDRESS_WIDTH{1'b0}};
            r_cache_data_in <= {CACHE_LINE_SIZE{1'b0}};
            r_cache_wen     <= 1'b0;
            r_resp_data     <= {CACHE_LINE_SIZE{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_win_found) begin
                        r_cache_address <= bus.req_address[w_win_idx*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                        r_cache_data_in <= bus.req_data[w_win_idx*CACHE_LINE_SIZE +: CACHE_LINE_SIZE];
                        r_cache_wen     <= bus.req_wen[w_win_idx];
                        r_grant         <= w_win_idx;
                        r_cnt           <= {CNT_W{1'b0}};
                    end else begin
                        r_cnt           <= r_cnt;
                    end
                end
                S_WAIT: begin
                    if (bus.cache_hit) begin
                        r_resp_data <= bus.cache_data_out;
                        r_err       <= 1'b0;
                    end else begin
                        r_err <= w_timeout;
                        r_cnt <= (r_cnt == CNT_MAX) ? r_cnt : r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                S_RESP: begin
                    r_rr_ptr <= (r_grant == PTR_LAST) ? {PTR_W{1'b0}} : r_grant + {{(PTR_W-1){1'b0}}, 1'b1};
                end
                default: begin
                    r_rr_ptr <= r_rr_ptr;
                end
            endcase
        end
    end

    // Output decode from the state register; cache_wen is only driven while the request is on the port.
    always_comb begin
        w_req_ready       = REQ_ZERO;
        w_resp_valid      = REQ_ZERO;
        w_resp_error      = REQ_ZERO;
        w_cache_req_valid = 1'b0;
        w_cache_wen       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_req_ready = w_win_found ? (REQ_ONE << w_win_idx) : REQ_ZERO;
            end
            S_WAIT: begin
                w_cache_req_valid = 1'b1;
                w_cache_wen       = r_cache_wen;
            end
            S_RESP: begin
                w_resp_valid = REQ_ONE << r_grant;
                w_resp_error = r_err ? (REQ_ONE << r_grant) : REQ_ZERO;
            end
            default: begin
                w_req_ready = REQ_ZERO;
            end
        endcase
    end

    assign bus.req_ready       = w_req_ready;
    assign bus.resp_valid      = w_resp_valid;
    assign bus.resp_error      = w_resp_error;
    assign bus.resp_data       = r_resp_data;
    assign bus.cache_req_valid = w_cache_req_valid;
    assign bus.cache_address   = r_cache_address;
    assign bus.cache_data_in   = r_cache_data_in;
    assign bus.cache_wen       = w_cache_wen;
endmodule

// File: tb/tb_cache_req_arbiter.sv
// Self-checking bench for cache_req_arbiter: a transaction table plus hand-written round-robin and reset sequences,
// with a response scoreboard filled at acceptance and drained by a response monitor.
module tb_cache_req_arbiter;
    localparam int TO = 8;

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_pass;
    int   last_resp_cyc;
    logic [31:0] model_data;

    typedef struct {
        int          req;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wen;
        int          hit_delay;   // WAIT cycle index of the hit; -1 = never
        logic [31:0] hdata;
        logic        other_valid; // other requester asserts valid during WAIT
    } vec_t;

    typedef struct {
        int          owner;
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[6];

    cache_req_arbiter_if #(.ADDRESS_WIDTH(32), .CACHE_LINE_SIZE(32), .NUM_REQ(2)) bus ();

    cache_req_arbiter #(
        .ADDRESS_WIDTH(32), .CACHE_LINE_SIZE(32), .NUM_REQ(2), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [1:0] oh(input int i);
        logic [1:0] one;
        one = 2'b01;
        return one << i;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response monitor: every resp_valid pulse must match the oldest scoreboard entry.
    always @(negedge clk) begin
        exp_t e;
        if (bus.resp_valid != 2'b00) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", {62'd0, bus.resp_valid}, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("resp_owner", {62'd0, bus.resp_valid}, {62'd0, oh(e.owner)});
                chk("resp_error", {62'd0, bus.resp_error}, e.err ? {62'd0, oh(e.owner)} : 64'd0);
                chk("resp_data", {32'd0, bus.resp_data}, {32'd0, e.data});
                last_resp_cyc = cyc;
            end
        end
    end

    task automatic run_txn(input vec_t v);
        int          t0;
        int          k;
        logic        exp_err;
        logic [31:0] exp_data;
        @(negedge clk);
        bus.req_valid   = oh(v.req);
        bus.req_address = {32'hFFFF_0000, 32'hFFFF_0000};
        bus.req_data    = {32'hEEEE_0000, 32'hEEEE_0000};
        bus.req_address[v.req*32 +: 32] = v.addr;
        bus.req_data[v.req*32 +: 32]    = v.wdata;
        bus.req_wen     = v.wen ? oh(v.req) : ~oh(v.req);
        bus.cache_hit   = 1'b0;
        last_resp_cyc   = -1;
        #1;
        chk("accept_ready", {62'd0, bus.req_ready}, {62'd0, oh(v.req)});
        t0       = cyc;
        exp_err  = (v.hit_delay < 0) || (v.hit_delay > TO - 1);
        k        = exp_err ? TO - 1 : v.hit_delay;
        exp_data = exp_err ? model_data : v.hdata;
        model_data = exp_data;
        sb.push_back('{v.req, exp_err, exp_data});
        for (int i = 0; i <= k; i++) begin
            @(negedge clk);
            bus.req_valid      = v.other_valid ? oh(1 - v.req) : 2'b00;
            bus.req_address    = ~bus.req_address;
            bus.req_data       = ~bus.req_data;
            bus.req_wen        = ~bus.req_wen;
            bus.cache_hit      = (i == v.hit_delay);
            bus.cache_data_out = (i == v.hit_delay) ? v.hdata : (32'h0BAD_0000 + i);
            #1;
            chk("wait_valid", {63'd0, bus.cache_req_valid}, 64'd1);
            chk("wait_addr", {32'd0, bus.cache_address}, {32'd0, v.addr});
            chk("wait_wdata", {32'd0, bus.cache_data_in}, {32'd0, v.wdata});
            chk("wait_wen", {63'd0, bus.cache_wen}, {63'd0, v.wen});
            chk("wait_ready", {62'd0, bus.req_ready}, 64'd0);
        end
        @(negedge clk);
        bus.req_valid = 2'b00;
        bus.cache_hit = 1'b0;
        #2;
        chk("resp_latency", 64'(last_resp_cyc), 64'(t0 + 2 + k));
        chk("resp_cache_valid", {63'd0, bus.cache_req_valid}, 64'd0);
        chk("resp_cache_wen", {63'd0, bus.cache_wen}, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] exp_rdy;
        cyc = 0; n_checks = 0; n_pass = 0; last_resp_cyc = -1; model_data = 32'h0;

        vecs[0] = '{0, 32'h0000_1040, 32'h0000_0000, 1'b0,  0, 32'hDEAD_BEEF, 1'b0};
        vecs[1] = '{1, 32'h0000_2000, 32'h1234_5678, 1'b1,  5, 32'hCAFE_0001, 1'b1};
        vecs[2] = '{0, 32'h0000_3000, 32'h0000_0000, 1'b0, -1, 32'h0000_0000, 1'b1};
        vecs[3] = '{1, 32'h0000_4000, 32'h0000_0000, 1'b0,  0, 32'h55AA_55AA, 1'b0};
        vecs[4] = '{0, 32'h0000_6000, 32'hAAAA_5555, 1'b1,  7, 32'h1357_9BDF, 1'b0};
        vecs[5] = '{1, 32'h0000_7000, 32'h0000_0000, 1'b0,  2, 32'h2468_ACE0, 1'b0};

        rst = 1'b0;
        bus.req_valid = 2'b00; bus.req_address = 64'd0; bus.req_data = 64'd0; bus.req_wen = 2'b00;
        bus.cache_hit = 1'b0;  bus.cache_data_out = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {62'd0, bus.req_ready}, 64'd0);
        chk("rst_resp_valid", {62'd0, bus.resp_valid}, 64'd0);
        chk("rst_resp_error", {62'd0, bus.resp_error}, 64'd0);
        chk("rst_resp_data", {32'd0, bus.resp_data}, 64'd0);
        chk("rst_cache_valid", {63'd0, bus.cache_req_valid}, 64'd0);
        chk("rst_cache_addr", {32'd0, bus.cache_address}, 64'd0);
        chk("rst_cache_wdata", {32'd0, bus.cache_data_in}, 64'd0);
        chk("rst_cache_wen", {63'd0, bus.cache_wen}, 64'd0);
        rst = 1'b1;

        for (int v = 0; v < 6; v++) begin
            run_txn(vecs[v]);
        end

        // Both requesters valid, every request hits at once: grants alternate every 3 cycles.
        bus.cache_hit = 1'b1;
        for (int m = 0; m < 12; m++) begin
            @(negedge clk);
            bus.req_valid      = 2'b11;
            bus.req_address    = {32'h0000_5100 + m, 32'h0000_5000 + m};
            bus.req_wen        = 2'b00;
            bus.cache_data_out = 32'hA000_0000 + m;
            #1;
            if (m % 3 == 0) begin
                exp_rdy = oh((m / 3) % 2);
                sb.push_back('{(m / 3) % 2, 1'b0, 32'hA000_0000 + m + 1});
                model_data = 32'hA000_0000 + m + 1;
            end else begin
                exp_rdy = 2'b00;
            end
            chk("rr_ready", {62'd0, bus.req_ready}, {62'd0, exp_rdy});
        end
        @(negedge clk);
        bus.req_valid = 2'b00;
        bus.cache_hit = 1'b0;

        // Move the pointer to requester 1, then reset asynchronously in the middle of a WAIT.
        run_txn('{0, 32'h0000_8000, 32'h0, 1'b0, 0, 32'h0F0F_0F0F, 1'b0});
        @(negedge clk);
        bus.req_valid = 2'b01;
        bus.req_address = {32'h0000_9100, 32'h0000_9000};
        #1;
        chk("pre_rst_ready", {62'd0, bus.req_ready}, 64'd1);
        @(negedge clk);
        bus.req_valid = 2'b00;
        #1;
        chk("pre_rst_wait", {63'd0, bus.cache_req_valid}, 64'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_valid", {63'd0, bus.cache_req_valid}, 64'd0);
        chk("async_rst_addr", {32'd0, bus.cache_address}, 64'd0);
        chk("async_rst_resp_data", {32'd0, bus.resp_data}, 64'd0);
        model_data = 32'h0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        bus.req_valid = 2'b11;
        #1;
        chk("post_rst_grant", {62'd0, bus.req_ready}, 64'd1);
        sb.push_back('{0, 1'b0, 32'h7777_1234});
        @(negedge clk);
        bus.req_valid = 2'b00;
        bus.cache_hit = 1'b1;
        bus.cache_data_out = 32'h7777_1234;
        #1;
        chk("post_rst_addr", {32'd0, bus.cache_address}, {32'd0, 32'h0000_9000});
        @(negedge clk);
        bus.cache_hit = 1'b0;
        repeat (3) @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
